// File: rtl/mcycle_core.sv
// mcycle_core: parametrised multi-cycle load/store core with memory handshake,
// single-step gating, HALT, illegal-opcode flag and debug readout. Define OVERFLOW_TRAP_EN to trap on signed overflow.
module mcycle_core #(
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned REG_ADDR  = 4,
  parameter int unsigned PC_RESET  = 0
) (
  input  logic                 DCLK,
  input  logic                 RSTn,
  output logic                 MEM_REQ,
  output logic                 MEM_WE,
  output logic [WORD_SIZE-1:0] MADDR,
  output logic [WORD_SIZE-1:0] MDATAOUT,
  input  logic [WORD_SIZE-1:0] MDATAIN,
  input  logic                 MEM_RDY,
  input  logic                 STEP_MODE,
  input  logic                 STEP,
  input  logic [REG_ADDR-1:0]  DBG_RADDR,
  output logic [WORD_SIZE-1:0] DBG_RDATA,
  output logic [WORD_SIZE-1:0] PC_OUT,
  output logic [WORD_SIZE-1:0] IR_OUT,
  output logic [2:0]           STAGE_OUT,
  output logic                 HALTED,
  output logic                 ILLEGAL,
  output logic                 OVF
);
  localparam int unsigned W    = WORD_SIZE;
  localparam int unsigned IMW  = W - 4 - REG_ADDR;
  localparam int unsigned TGW  = W - 4;
  localparam int unsigned NREG = 2 ** REG_ADDR;
  localparam logic [W-1:0] PC_INIT = W'(PC_RESET);

  localparam logic [3:0] OP_LW   = 4'h1;
  localparam logic [3:0] OP_SW   = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_SLT  = 4'h7;
  localparam logic [3:0] OP_ADDI = 4'h8;
  localparam logic [3:0] OP_BEQ  = 4'h9;
  localparam logic [3:0] OP_JUMP = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t state_q, state_d;
  logic [W-1:0] pc_q, ir_q, a_q, b_q, alu_q, mdr_q;
  logic [W-1:0] regs [NREG];
  logic         illegal_q;
  logic [W-1:0] alu_d, pc_d, wr_data, im, off, tgt;
  logic [3:0]   op;
  logic [REG_ADDR-1:0] r1, r2, r3;
  logic adv, alu_op, writes_r1, op_illegal, wr_en, trap;

  // Instruction field extraction from the held IR
  assign op  = ir_q[W-1 -: 4];
  assign r1  = ir_q[W-5 -: REG_ADDR];
  assign r2  = ir_q[W-5-REG_ADDR -: REG_ADDR];
  assign r3  = ir_q[W-5-2*REG_ADDR -: REG_ADDR];
  assign im  = W'(ir_q[IMW-1:0]);
  assign off = {{(W-REG_ADDR){r3[REG_ADDR-1]}}, r3};
  assign tgt = W'(ir_q[TGW-1:0]);

  assign adv        = !STEP_MODE || STEP;
  assign alu_op     = (op >= OP_ADD) && (op <= OP_SLT);
  assign writes_r1  = alu_op || (op == OP_ADDI) || (op == OP_LW);
  assign op_illegal = (op >= 4'hB) && (op <= 4'hE);
  assign wr_en      = adv && (state_q == S_WB) && writes_r1 && !trap;
  assign wr_data    = (op == OP_LW) ? mdr_q : alu_q;

  always_ff @(posedge DCLK or negedge RSTn) begin
    if (!RSTn) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (adv && MEM_RDY) state_d = S_DECODE;
      S_DECODE: if (adv) state_d = (op == OP_HALT) ? S_HALT : S_EXEC;
      S_EXEC:   if (adv) state_d = (op == OP_LW || op == OP_SW) ? S_MEM : S_WB;
      S_MEM:    if (adv && MEM_RDY) state_d = S_WB;
      S_WB:     if (adv) state_d = trap ? S_HALT : S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    alu_d = '0;
    case (op)
      OP_ADD:  alu_d = a_q + b_q;
      OP_SUB:  alu_d = a_q - b_q;
      OP_OR:   alu_d = a_q | b_q;
      OP_AND:  alu_d = a_q & b_q;
      OP_SLT:  alu_d = W'(a_q < b_q);
      OP_ADDI: alu_d = a_q + im;
      default: alu_d = '0;
    endcase
  end

  // Branch compares the operands latched at decode, which stay valid through WB
  always_comb begin
    pc_d = pc_q + W'(1);
    case (op)
      OP_BEQ:  if (a_q == b_q) pc_d = pc_q + off;
      OP_JUMP: pc_d = tgt;
      default: pc_d = pc_q + W'(1);
    endcase
  end

  always_ff @(posedge DCLK or negedge RSTn) begin
    if (!RSTn) begin
      pc_q      <= PC_INIT;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_q     <= '0;
      mdr_q     <= '0;
      illegal_q <= 1'b0;
    end else if (adv) begin
      case (state_q)
        S_FETCH:  if (MEM_RDY) ir_q <= MDATAIN;
        S_DECODE: begin
          a_q <= alu_op ? regs[r2] : regs[r1];
          b_q <= alu_op ? regs[r3] : regs[r2];
          if (op_illegal) illegal_q <= 1'b1;
        end
        S_EXEC:   alu_q <= alu_d;
        S_MEM:    if (MEM_RDY && op == OP_LW) mdr_q <= MDATAIN;
        S_WB:     if (!trap) pc_q <= pc_d;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge DCLK or negedge RSTn) begin
    if (!RSTn)      regs <= '{default: '0};
    else if (wr_en) regs[r1] <= wr_data;
  end

`ifdef OVERFLOW_TRAP_EN
  logic ovf_d, ovf_pend_q, ovf_q;

  // im is zero-extended, so ADDI can only overflow from positive to negative
  always_comb begin
    ovf_d = 1'b0;
    case (op)
      OP_ADD:  ovf_d = (a_q[W-1] == b_q[W-1]) && (alu_d[W-1] != a_q[W-1]);
      OP_SUB:  ovf_d = (a_q[W-1] != b_q[W-1]) && (alu_d[W-1] != a_q[W-1]);
      OP_ADDI: ovf_d = !a_q[W-1] && alu_d[W-1];
      default: ovf_d = 1'b0;
    endcase
  end

  always_ff @(posedge DCLK or negedge RSTn) begin
    if (!RSTn) begin
      ovf_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else if (adv) begin
      if (state_q == S_EXEC) ovf_pend_q <= ovf_d;
      if (state_q == S_WB && ovf_pend_q) ovf_q <= 1'b1;
    end
  end

  assign trap = ovf_pend_q;
  assign OVF  = ovf_q;
`else
  assign trap = 1'b0;
  assign OVF  = 1'b0;
`endif

  // Request is masked while reset is held so nothing is presented to memory
  assign MEM_REQ   = RSTn && ((state_q == S_FETCH) || (state_q == S_MEM));
  assign MEM_WE    = (state_q == S_MEM) && (op == OP_SW);
  assign MADDR     = (state_q == S_MEM) ? im : pc_q;
  assign MDATAOUT  = (state_q == S_MEM) ? a_q : '0;
  assign DBG_RDATA = regs[DBG_RADDR];
  assign PC_OUT    = pc_q;
  assign IR_OUT    = ir_q;
  assign STAGE_OUT = state_q;
  assign HALTED    = (state_q == S_HALT);
  assign ILLEGAL   = illegal_q;

endmodule

// File: tb/tb_mcycle_core.sv
// Self-checking bench for mcycle_core: small program images per scenario, store scoreboard
// checked at the memory handshake, and direct checks of PC/registers/status outputs.
module tb_mcycle_core;
  logic        DCLK, RSTn, MEM_REQ, MEM_WE, MEM_RDY, STEP_MODE, STEP;
  logic        HALTED, ILLEGAL, OVF;
  logic [15:0] MADDR, MDATAOUT, MDATAIN, DBG_RDATA, PC_OUT, IR_OUT;
  logic [3:0]  DBG_RADDR;
  logic [2:0]  STAGE_OUT;
  logic [15:0] mem [256];

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } st_t;
  st_t sb_q[$];

  int n_chk = 0;
  int n_fail = 0;
  logic [2:0] seq [6];
  logic [2:0] prev;
  logic       req_seen;

  mcycle_core dut (
    .DCLK(DCLK), .RSTn(RSTn), .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MADDR(MADDR),
    .MDATAOUT(MDATAOUT), .MDATAIN(MDATAIN), .MEM_RDY(MEM_RDY), .STEP_MODE(STEP_MODE),
    .STEP(STEP), .DBG_RADDR(DBG_RADDR), .DBG_RDATA(DBG_RDATA), .PC_OUT(PC_OUT),
    .IR_OUT(IR_OUT), .STAGE_OUT(STAGE_OUT), .HALTED(HALTED), .ILLEGAL(ILLEGAL), .OVF(OVF)
  );

  assign MDATAIN = mem[MADDR[7:0]];

  initial DCLK = 1'b0;
  always #10 DCLK = ~DCLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // One clock per iteration; completed stores are popped against the scoreboard
  task automatic tick(input int n);
    st_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge DCLK);
      if (RSTn && MEM_REQ && MEM_WE && MEM_RDY && (!STEP_MODE || STEP)) begin
        e = (sb_q.size() > 0) ? sb_q.pop_front() : '1;
        check_eq("sb_store", {MADDR, MDATAOUT}, e);
      end
      @(posedge DCLK);
      #1;
    end
  endtask

  task automatic chk_reg(input string tag, input int idx, input logic [15:0] expv);
    DBG_RADDR = 4'(idx);
    #1;
    check_eq(tag, 32'(DBG_RDATA), 32'(expv));
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  endtask

  task automatic reset_checks(input int ridx);
    check_eq("rst_mem_req", 32'(MEM_REQ), 0);
    check_eq("rst_mem_we", 32'(MEM_WE), 0);
    check_eq("rst_maddr", 32'(MADDR), 0);
    check_eq("rst_mdataout", 32'(MDATAOUT), 0);
    check_eq("rst_pc", 32'(PC_OUT), 0);
    check_eq("rst_ir", 32'(IR_OUT), 0);
    check_eq("rst_stage", 32'(STAGE_OUT), 0);
    check_eq("rst_flags", {29'h0, HALTED, ILLEGAL, OVF}, 0);
    chk_reg("rst_reg", ridx, 16'h0000);
  endtask

  // Hold reset for two edges with the program already loaded, then release
  task automatic start();
    RSTn = 1'b0; STEP_MODE = 1'b0; STEP = 1'b0; MEM_RDY = 1'b1; DBG_RADDR = '0;
    repeat (2) @(posedge DCLK);
    #1;
    RSTn = 1'b1;
  endtask

  initial begin
    RSTn = 1'b0; STEP_MODE = 1'b0; STEP = 1'b0; MEM_RDY = 1'b1; DBG_RADDR = '0;
    seq = '{3'd1, 3'd2, 3'd4, 3'd0, 3'd1, 3'd5};

    // ADDI, ADDI, ADD then a store of the sum
    clear_mem();
    mem[0] = 16'h8105; mem[1] = 16'h8203; mem[2] = 16'h3312; mem[3] = 16'h2350; mem[4] = 16'hF000;
    RSTn = 1'b0;
    repeat (2) @(posedge DCLK);
    #1;
    reset_checks(3);
    RSTn = 1'b1;
    tick(12);
    check_eq("t1_pc", 32'(PC_OUT), 3);
    chk_reg("t1_reg3", 3, 16'h0008);
    chk_reg("t1_reg1", 1, 16'h0005);
    sb_q.push_back('{addr: 16'h0050, data: 16'h0008});
    tick(5);
    check_eq("t1_pc_after_sw", 32'(PC_OUT), 4);
    tick(2);
    check_eq("t1_halted", 32'(HALTED), 1);

    // LW with three wait cycles in S_MEM, then SW of the loaded word
    clear_mem();
    mem[0] = 16'h1420; mem[1] = 16'h2421; mem[2] = 16'hF000; mem[8'h20] = 16'hBEEF;
    sb_q.push_back('{addr: 16'h0021, data: 16'hBEEF});
    start();
    tick(3);
    MEM_RDY = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check_eq("t2_stage_mem", 32'(STAGE_OUT), 3);
      check_eq("t2_req_held", {15'h0, MEM_REQ, MADDR}, 32'h0001_0020);
      check_eq("t2_we_low", 32'(MEM_WE), 0);
      if (k < 3) tick(1);
    end
    MEM_RDY = 1'b1;
    tick(1);
    check_eq("t2_stage_wb", 32'(STAGE_OUT), 4);
    chk_reg("t2_reg4_prewb", 4, 16'h0000);
    tick(1);
    check_eq("t2_pc", 32'(PC_OUT), 1);
    check_eq("t2_stage_fetch", 32'(STAGE_OUT), 0);
    chk_reg("t2_reg4", 4, 16'hBEEF);
    tick(5);
    check_eq("t2_pc_after_sw", 32'(PC_OUT), 2);

    // BEQ taken backwards, BEQ not taken, JUMP
    clear_mem();
    mem[0] = 16'h8105; mem[1] = 16'h8205; mem[2] = 16'hA004; mem[3] = 16'h8201;
    mem[4] = 16'h912F; mem[5] = 16'hA0FF; mem[8'hFF] = 16'hF000;
    start();
    tick(16);
    check_eq("t3_beq_taken", 32'(PC_OUT), 3);
    tick(8);
    check_eq("t3_beq_not_taken", 32'(PC_OUT), 5);
    chk_reg("t3_reg2", 2, 16'h0006);
    tick(4);
    check_eq("t3_jump", 32'(PC_OUT), 32'h00FF);
    tick(2);
    check_eq("t3_halt", {28'h0, HALTED, STAGE_OUT}, {28'h0, 1'b1, 3'd5});
    check_eq("t3_halt_pc", 32'(PC_OUT), 32'h00FF);

    // Single-step: one state per STEP pulse, then HALT is terminal
    clear_mem();
    mem[0] = 16'h8105; mem[1] = 16'hF000;
    start();
    STEP_MODE = 1'b1;
    prev = 3'd0;
    for (int k = 0; k < 6; k++) begin
      tick(9);
      check_eq("t4_hold", 32'(STAGE_OUT), 32'(prev));
      if (k == 0) check_eq("t4_req_wait", 32'(MEM_REQ), 1);
      STEP = 1'b1;
      tick(1);
      STEP = 1'b0;
      check_eq("t4_step", 32'(STAGE_OUT), 32'(seq[k]));
      prev = seq[k];
    end
    check_eq("t4_halted", 32'(HALTED), 1);
    chk_reg("t4_reg1", 1, 16'h0005);
    req_seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      STEP = k[0];
      tick(1);
      req_seen = req_seen | MEM_REQ;
    end
    STEP = 1'b0;
    check_eq("t4_req_never", 32'(req_seen), 0);
    check_eq("t4_stays_halt", 32'(STAGE_OUT), 5);

    // Illegal opcode behaves as NOP; reset during a store abandons it
    clear_mem();
    mem[0] = 16'h8107; mem[1] = 16'hC000; mem[2] = 16'h2130;
    start();
    tick(4);
    check_eq("t5_pc1", {15'h0, ILLEGAL, PC_OUT}, 32'h0000_0001);
    tick(4);
    check_eq("t5_illegal", {15'h0, ILLEGAL, PC_OUT}, 32'h0001_0002);
    chk_reg("t5_reg1", 1, 16'h0007);
    chk_reg("t5_reg0", 0, 16'h0000);
    tick(3);
    check_eq("t5_sw_mem", {12'h0, 1'b0, STAGE_OUT, MADDR}, {12'h0, 1'b0, 3'd3, 16'h0030});
    check_eq("t5_sw_drive", {15'h0, MEM_WE, MDATAOUT}, 32'h0001_0007);
    RSTn = 1'b0;
    #1;
    reset_checks(1);
    repeat (2) @(posedge DCLK);
    #1;
    RSTn = 1'b1;

    // Signed overflow on ADD (0x7FFF + 1)
    clear_mem();
    mem[0] = 16'h1140; mem[1] = 16'h1241; mem[2] = 16'h3312; mem[3] = 16'hF000;
    mem[8'h40] = 16'h7FFF; mem[8'h41] = 16'h0001;
    start();
    tick(14);
    chk_reg("t6_reg1", 1, 16'h7FFF);
`ifdef OVERFLOW_TRAP_EN
    check_eq("t6_ovf", {30'h0, OVF, HALTED}, 32'h3);
    check_eq("t6_pc_frozen", 32'(PC_OUT), 2);
    chk_reg("t6_reg3_kept", 3, 16'h0000);
`else
    check_eq("t6_ovf", {30'h0, OVF, HALTED}, 32'h0);
    check_eq("t6_pc", 32'(PC_OUT), 3);
    chk_reg("t6_reg3_wrap", 3, 16'h8000);
    tick(2);
    check_eq("t6_halt", {30'h0, OVF, HALTED}, 32'h1);
`endif

    check_eq("sb_empty", 32'(sb_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
